// File: rtl/div_share_arbiter_pkg.sv
// Shared constants for the divider-sharing arbiter: default width, FSM state
// encoding and the quotient returned for a zero divisor.
package div_share_arbiter_pkg;

   localparam int W = 16;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CLR    = 3'd1;
   localparam logic [2:0] ST_LAUNCH = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_RESP   = 3'd4;

   localparam logic [W-1:0] DIV0_Q = {W{1'b1}};

endpackage

// File: rtl/div_share_arbiter_if.sv
// Requester-side bus of the divider-sharing arbiter: per-requester job
// handshake plus the shared, owner-tagged response.
interface div_share_arbiter_if #(
   parameter int NREQ = 2,
   parameter int W    = 16
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   rsp_valid;
   logic [W-1:0]      rsp_q;
   logic [W-1:0]      rsp_r;
   logic              rsp_err;

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, rsp_valid, rsp_q, rsp_r, rsp_err
   );

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, rsp_valid, rsp_q, rsp_r, rsp_err
   );
endinterface

// File: rtl/div_share_arbiter_rr_pick.sv
// Round-robin picker: first set valid bit at or above the pointer, wrapping,
// returned as a one-hot grant plus its index.
module div_share_arbiter_rr_pick #(
   parameter int NREQ = 2,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [PW-1:0]   idx_o,
   output logic            any_o
);

   always_comb begin
      int   j;
      logic found;
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr_i) + k) % NREQ;
         if (!found && valid_i[j]) begin
            found      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = PW'(j);
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one sequential divider between NREQ requesters with round-robin
// grant, a zero-divisor shortcut and a watchdog on the divider's done.
//
// state  | meaning
// IDLE   | offer the round-robin grant, latch the accepted job
// CLR    | hold the divider in reset for one cycle
// LAUNCH | pulse div_start with the latched operands
// WAIT   | wait for div_done, abort on watchdog expiry
// RESP   | one-cycle response pulse to the job owner
module div_share_arbiter
   import div_share_arbiter_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int W       = div_share_arbiter_pkg::W,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   div_share_arbiter_if.slave   bus,
   output logic                 busy,
   output logic                 div_rst,
   output logic                 div_start,
   output logic [W-1:0]         div_a,
   output logic [W-1:0]         div_b,
   input  logic                 div_done,
   input  logic [W-1:0]         div_y,
   input  logic [W-1:0]         div_rem
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT);

   logic [2:0]      state_q,  state_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]   owner_q,  owner_d;
   logic [W-1:0]    op_a_q,   op_a_d;
   logic [W-1:0]    op_b_q,   op_b_d;
   logic [CW-1:0]   wdog_q,   wdog_d;
   logic [W-1:0]    quo_q,    quo_d;
   logic [W-1:0]    rem_q,    rem_d;
   logic            err_q,    err_d;

   logic [NREQ-1:0] pick_grant;
   logic [PW-1:0]   pick_idx;
   logic            pick_any;
   logic [W-1:0]    a_sel;
   logic [W-1:0]    b_sel;
   logic [NREQ-1:0] rsp_valid_c;

   div_share_arbiter_rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_pick (
      .valid_i (bus.req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   assign a_sel = bus.req_a[pick_idx*W +: W];
   assign b_sel = bus.req_b[pick_idx*W +: W];

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      wdog_d   = wdog_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               owner_d  = pick_idx;
               op_a_d   = a_sel;
               op_b_d   = b_sel;
               rr_ptr_d = (pick_idx == PW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
               // A zero divisor never touches the divider.
               if (b_sel == '0) begin
                  quo_d   = {W{1'b1}};
                  rem_d   = a_sel;
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_CLR;
               end
            end
         end
         ST_CLR:    state_d = ST_LAUNCH;
         ST_LAUNCH: begin
            wdog_d  = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // done is checked first so it wins over a coincident timeout
            if (div_done) begin
               quo_d   = div_y;
               rem_d   = div_rem;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (wdog_q == CW'(TIMEOUT-1)) begin
               quo_d   = '0;
               rem_d   = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               wdog_d  = wdog_q + 1'b1;
            end
         end
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         wdog_q   <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         wdog_q   <= wdog_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      rsp_valid_c = '0;
      if (state_q == ST_RESP) rsp_valid_c[owner_q] = 1'b1;
   end

   assign bus.req_ready = (state_q == ST_IDLE && !rst) ? pick_grant : '0;
   assign bus.rsp_valid = rsp_valid_c;
   assign bus.rsp_q     = quo_q;
   assign bus.rsp_r     = rem_q;
   assign bus.rsp_err   = err_q;

   assign busy      = (state_q != ST_IDLE);
   assign div_rst   = rst | (state_q == ST_CLR);
   assign div_start = (state_q == ST_LAUNCH);
   assign div_a     = op_a_q;
   assign div_b     = op_b_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a behavioural sequential divider
// (fixed latency, optional never-done stub).
module tb_div_share_arbiter;

   localparam int NREQ    = 2;
   localparam int W       = 16;
   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_share_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

   logic         busy, div_rst, div_start, div_done;
   logic [W-1:0] div_a, div_b, div_y, div_rem;

   div_share_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .div_rst   (div_rst),
      .div_start (div_start),
      .div_a     (div_a),
      .div_b     (div_b),
      .div_done  (div_done),
      .div_y     (div_y),
      .div_rem   (div_rem)
   );

   // Divider model: done rises 6 cycles after the start cycle, held until reset.
   logic         stub;
   logic         m_run;
   int           m_cnt;
   logic [W-1:0] m_a, m_b;
   always @(posedge clk) begin
      if (div_rst) begin
         div_done <= 1'b0; m_run <= 1'b0; m_cnt <= 0;
         div_y <= '0; div_rem <= '0; m_a <= '0; m_b <= '0;
      end else if (div_start) begin
         m_run <= 1'b1; m_cnt <= 5; m_a <= div_a; m_b <= div_b;
      end else if (m_run && !stub) begin
         if (m_cnt == 1) begin
            div_done <= 1'b1; m_run <= 1'b0;
            div_y <= m_a / m_b; div_rem <= m_a % m_b;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_start = 0, n_divrst = 0, n_rsp = 0, n_acc = 0;
   int start_cyc = 0, rst_cyc = 0, done_cyc = 0, acc_cyc = 0, rsp_cyc = 0;
   int acc_who [0:15];
   logic            done_prev = 1'b0;
   logic            keep_valid = 1'b0;
   logic [NREQ-1:0] rsp_v;
   logic [W-1:0]    rsp_qv, rsp_rv;
   logic            rsp_ev;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full cycle: sample at negedge, then drop accepted valids after posedge.
   task automatic tick();
      logic [NREQ-1:0] acc;
      @(negedge clk);
      cyc++;
      acc = bus.req_valid & bus.req_ready;
      if (div_start) begin n_start++; start_cyc = cyc; end
      if (div_rst && !rst) begin n_divrst++; rst_cyc = cyc; end
      if (div_done && !done_prev) done_cyc = cyc;
      done_prev = div_done;
      if (|bus.rsp_valid) begin
         n_rsp++; rsp_cyc = cyc; rsp_v = bus.rsp_valid;
         rsp_qv = bus.rsp_q; rsp_rv = bus.rsp_r; rsp_ev = bus.rsp_err;
      end
      if (|acc) begin
         acc_cyc = cyc;
         if (n_acc < 16) acc_who[n_acc] = acc[1] ? 1 : 0;
         n_acc++;
      end
      @(posedge clk);
      #1;
      if (!keep_valid) bus.req_valid = bus.req_valid & ~acc;
   endtask

   task automatic wait_rsp(input string tag, input int budget);
      int n0;
      int k;
      n0 = n_rsp;
      k  = 0;
      while (n_rsp == n0 && k < budget) begin
         tick();
         k++;
      end
      chk(tag, 32'(n_rsp - n0), 32'd1);
   endtask

   initial begin
      int s0, r0, n0, a0, k;
      rst = 1'b1;
      stub = 1'b0;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      tick();
      tick();

      bus.req_a[0 +: W] = 16'd5; bus.req_b[0 +: W] = 16'd1;
      bus.req_valid = 2'b01;
      #1;
      chk("reset_ready",   32'(bus.req_ready), 32'd0);
      chk("reset_busy",    32'(busy),          32'd0);
      chk("reset_div_rst", 32'(div_rst),       32'd1);
      chk("reset_start",   32'(div_start),     32'd0);
      chk("reset_rsp",     32'(bus.rsp_valid), 32'd0);
      chk("reset_rsp_q",   32'(bus.rsp_q),     32'd0);
      chk("reset_div_a",   32'(div_a),         32'd0);
      bus.req_valid = '0;
      rst = 1'b0;
      tick();
      chk("idle_div_rst", 32'(div_rst), 32'd0);

      // 110 / 25 on requester 0
      bus.req_a[0 +: W] = 16'd110; bus.req_b[0 +: W] = 16'd25;
      bus.req_valid = 2'b01;
      s0 = n_start; r0 = n_divrst;
      wait_rsp("t1_rsp", 40);
      chk("t1_owner",   32'(rsp_v),  32'h1);
      chk("t1_q",       32'(rsp_qv), 32'd4);
      chk("t1_r",       32'(rsp_rv), 32'd10);
      chk("t1_err",     32'(rsp_ev), 32'd0);
      chk("t1_starts",  32'(n_start - s0),  32'd1);
      chk("t1_clrs",    32'(n_divrst - r0), 32'd1);
      chk("t1_clr2st",  32'(start_cyc - rst_cyc), 32'd1);
      chk("t1_latency", 32'(rsp_cyc - acc_cyc), 32'd9);

      rst = 1'b1; tick(); rst = 1'b0; tick();

      // simultaneous requests from pointer 0
      bus.req_a[0 +: W] = 16'd32200; bus.req_b[0 +: W] = 16'd37;
      bus.req_a[W +: W] = 16'd1234;  bus.req_b[W +: W] = 16'd56;
      bus.req_valid = 2'b11;
      #1;
      chk("t2_ready", 32'(bus.req_ready), 32'h1);
      wait_rsp("t2_rsp0", 40);
      chk("t2_owner0", 32'(rsp_v),  32'h1);
      chk("t2_q0",     32'(rsp_qv), 32'd870);
      chk("t2_r0",     32'(rsp_rv), 32'd10);
      wait_rsp("t2_rsp1", 40);
      chk("t2_owner1", 32'(rsp_v),  32'h2);
      chk("t2_q1",     32'(rsp_qv), 32'd22);
      chk("t2_r1",     32'(rsp_rv), 32'd2);
      chk("t2_err1",   32'(rsp_ev), 32'd0);

      // both requesters held valid for four jobs
      bus.req_a[0 +: W] = 16'd100; bus.req_b[0 +: W] = 16'd7;
      bus.req_a[W +: W] = 16'd200; bus.req_b[W +: W] = 16'd9;
      a0 = n_acc; n0 = n_rsp; k = 0;
      keep_valid = 1'b1;
      bus.req_valid = 2'b11;
      while (n_rsp - n0 < 4 && k < 200) begin
         tick();
         k++;
      end
      bus.req_valid = '0;
      keep_valid = 1'b0;
      chk("t6_jobs",   32'(n_acc - a0), 32'd4);
      chk("t6_grant0", 32'(acc_who[a0]),   32'd0);
      chk("t6_grant1", 32'(acc_who[a0+1]), 32'd1);
      chk("t6_grant2", 32'(acc_who[a0+2]), 32'd0);
      chk("t6_grant3", 32'(acc_who[a0+3]), 32'd1);
      chk("t6_q_last", 32'(rsp_qv), 32'd22);
      chk("t6_r_last", 32'(rsp_rv), 32'd2);

      // divide by zero on requester 1
      bus.req_a[W +: W] = 16'd500; bus.req_b[W +: W] = 16'd0;
      bus.req_valid = 2'b10;
      s0 = n_start;
      wait_rsp("t3_rsp", 10);
      chk("t3_owner",   32'(rsp_v),  32'h2);
      chk("t3_latency", 32'(rsp_cyc - acc_cyc), 32'd1);
      chk("t3_q",       32'(rsp_qv), 32'hFFFF);
      chk("t3_r",       32'(rsp_rv), 32'd500);
      chk("t3_err",     32'(rsp_ev), 32'd1);
      chk("t3_starts",  32'(n_start - s0), 32'd0);

      // divider that never finishes
      stub = 1'b1;
      bus.req_a[0 +: W] = 16'd9; bus.req_b[0 +: W] = 16'd3;
      bus.req_valid = 2'b01;
      wait_rsp("t4_rsp", 100);
      chk("t4_owner",   32'(rsp_v),  32'h1);
      chk("t4_q",       32'(rsp_qv), 32'd0);
      chk("t4_r",       32'(rsp_rv), 32'd0);
      chk("t4_err",     32'(rsp_ev), 32'd1);
      chk("t4_latency", 32'(rsp_cyc - acc_cyc), 32'd67);
      tick();
      chk("t4_idle", 32'(busy), 32'd0);
      stub = 1'b0;

      // reset while waiting on 7 / 2
      bus.req_a[0 +: W] = 16'd7; bus.req_b[0 +: W] = 16'd2;
      bus.req_valid = 2'b01;
      s0 = n_start; n0 = n_rsp; k = 0;
      while (n_start == s0 && k < 20) begin
         tick();
         k++;
      end
      chk("t5_launched", 32'(n_start - s0), 32'd1);
      tick();
      tick();
      chk("t5_busy_wait", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("t5_div_rst", 32'(div_rst), 32'd1);
      tick();
      rst = 1'b0;
      chk("t5_busy_after", 32'(busy), 32'd0);
      for (int i = 0; i < 20; i++) tick();
      chk("t5_no_rsp", 32'(n_rsp - n0), 32'd0);
      bus.req_valid = 2'b01;
      wait_rsp("t5_rsp", 40);
      chk("t5_owner", 32'(rsp_v),  32'h1);
      chk("t5_q",     32'(rsp_qv), 32'd3);
      chk("t5_r",     32'(rsp_rv), 32'd1);
      chk("t5_err",   32'(rsp_ev), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
